// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read byte FIFO into a valid/ready
// byte stream with burst framing, using a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16,
  parameter int BLEN_W    = 16
) (
  input  logic              clk_r,
  input  logic              rst,
  input  logic              enable,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       words_sent
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [BLEN_W-1:0] LAST_BEAT =
    BLEN_W'(BURST_LEN - 1);

  state_t            state;
  logic [DATA_W-1:0] skid [2];
  logic              hd;
  logic [1:0]        occ;
  logic              inflight;
  logic [BLEN_W-1:0] beat;
  logic              pop;
  logic              push;
  logic              tl;
  logic [2:0]        used;
  logic [2:0]        room;

  assign m_valid = (occ != 2'd0);
  assign m_data  = skid[hd];
  assign m_last  = m_valid & (beat == LAST_BEAT);
  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  assign tl      = hd ^ occ[0];

  // a slot freed by this cycle's pop can be reused by the read issued now
  assign used  = {1'b0, occ} + {2'b00, inflight};
  assign room  = 3'd2 + {2'b00, pop};
  assign rd_en = (state == STREAM) & ~buf_empty
               & (used < room);

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (!enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (enable) begin
            state <= STREAM;
          end else if (occ == 2'd0 && !inflight) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      skid[0]  <= '0;
      skid[1]  <= '0;
      hd       <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= rd_en;
      if (push) begin
        skid[tl] <= buf_out;
      end
      if (pop) begin
        hd <= ~hd;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      beat       <= '0;
      words_sent <= 16'd0;
    end else if (pop) begin
      words_sent <= words_sent + 16'd1;
      if (beat == LAST_BEAT) begin
        beat <= '0;
      end else begin
        beat <= beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a registered-read FIFO model
// and a byte scoreboard; a second instance runs with BURST_LEN=1.
module tb_fifo_rd_stream;

  logic        clk_r = 1'b0;
  logic        rst;
  logic        enable;
  logic        buf_empty;
  logic [7:0]  buf_out;
  logic        m_ready;
  logic        rd_en, m_valid, m_last, busy;
  logic [7:0]  m_data;
  logic [15:0] words_sent;
  logic        b1_rd_en, b1_valid, b1_last, b1_busy;
  logic [7:0]  b1_data;
  logic [15:0] b1_words;

  int          nchk = 0;
  int          nerr = 0;
  logic [7:0]  fmem [256];
  int          wp = 0;
  int          rp = 0;
  bit          inf_src = 1'b0;
  logic [7:0]  sb [$];
  int          ord, minf, bm, acc_cnt, rd_cnt;
  logic [15:0] wm;
  bit          s_rd, s_acc, pstall, plast, last_last;
  logic [7:0]  pdata, last_acc;
  int          base, rdb;
  bit          got;

  always #5 clk_r = ~clk_r;

  assign buf_empty = inf_src ? 1'b0 : (wp == rp);

  fifo_rd_stream #(.DATA_W(8), .BURST_LEN(16), .BLEN_W(16)) u_dut (
    .clk_r(clk_r), .rst(rst), .enable(enable),
    .buf_empty(buf_empty), .buf_out(buf_out), .rd_en(rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .words_sent(words_sent)
  );

  fifo_rd_stream #(.DATA_W(8), .BURST_LEN(1), .BLEN_W(16)) u_b1 (
    .clk_r(clk_r), .rst(rst), .enable(enable),
    .buf_empty(buf_empty), .buf_out(buf_out), .rd_en(b1_rd_en),
    .m_data(b1_data), .m_valid(b1_valid), .m_ready(m_ready),
    .m_last(b1_last), .busy(b1_busy), .words_sent(b1_words)
  );

  task automatic chk(input string tag, input logic [31:0] got_v,
                     input logic [31:0] want);
    nchk++;
    assert (got_v === want) else begin
      nerr++;
      $error("FAIL %s: got %0h, want %0h", tag, got_v, want);
    end
  endtask

  task automatic mod_clear();
    ord = 0; minf = 0; bm = 0; wm = 16'd0;
    sb.delete();
    s_rd = 1'b0; s_acc = 1'b0; pstall = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wp[7:0]] = d;
    wp++;
  endtask

  // sample and check just before the edge
  task automatic neg();
    int occ_m;
    int pn;
    @(negedge clk_r);
    occ_m = ord - minf;
    pn = (occ_m > 0 && m_ready) ? 1 : 0;
    chk("occ_bound", 32'(occ_m <= 2), 32'd1);
    chk("m_valid", 32'(m_valid), 32'(occ_m > 0));
    chk("b1_valid", 32'(b1_valid), 32'(occ_m > 0));
    chk("words", 32'(words_sent), 32'(wm));
    chk("b1_words", 32'(b1_words), 32'(wm));
    if (occ_m > 0) begin
      chk("m_data", 32'(m_data), 32'(sb[0]));
      chk("m_last", 32'(m_last), 32'(bm == 15));
      chk("b1_data", 32'(b1_data), 32'(sb[0]));
      chk("b1_last", 32'(b1_last), 32'd1);
    end else begin
      chk("m_last_idle", 32'(m_last), 32'd0);
      chk("b1_last_idle", 32'(b1_last), 32'd0);
    end
    if (pstall) begin
      chk("hold_data", 32'(m_data), 32'(pdata));
      chk("hold_last", 32'(m_last), 32'(plast));
    end
    if (rd_en) begin
      chk("no_underflow", 32'(buf_empty), 32'd0);
      chk("credit", 32'((ord - pn) < 2), 32'd1);
    end
    if (b1_rd_en) begin
      chk("b1_credit", 32'((ord - pn) < 2), 32'd1);
    end
    s_rd   = rd_en;
    s_acc  = m_valid & m_ready;
    pstall = m_valid & ~m_ready;
    pdata  = m_data;
    plast  = m_last;
  endtask

  // advance the FIFO model and scoreboard past the edge
  task automatic pos();
    @(posedge clk_r);
    #1;
    ord  = ord + int'(s_rd) - int'(s_acc);
    minf = int'(s_rd);
    if (s_acc) begin
      void'(sb.pop_front());
      bm = (bm == 15) ? 0 : bm + 1;
      wm++;
      acc_cnt++;
      last_acc  = pdata;
      last_last = plast;
    end
    if (s_rd) begin
      buf_out = inf_src ? rp[7:0] : fmem[rp[7:0]];
      sb.push_back(buf_out);
      rp++;
      rd_cnt++;
    end
  endtask

  task automatic cyc();
    neg();
    pos();
  endtask

  task automatic rst_pulse();
    neg();
    #1 rst = 1'b1;
    mod_clear();
    #1 rst = 1'b0;
    pos();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; buf_out = 8'h00;
    acc_cnt = 0; rd_cnt = 0; last_acc = 8'h00; last_last = 1'b0;
    mod_clear();
    #12;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_words", 32'(words_sent), 32'd0);
    @(negedge clk_r);
    rst = 1'b0;
    pos();

    // basic drain
    for (int i = 0; i < 16; i++) push(8'(i));
    enable = 1'b1; m_ready = 1'b1;
    neg(); chk("t1_idle_rd", 32'(rd_en), 32'd0); pos();
    neg();
    chk("t1_rd0", 32'(rd_en), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_nv0", 32'(m_valid), 32'd0);
    pos();
    neg(); chk("t1_nv1", 32'(m_valid), 32'd0); pos();
    for (int i = 0; i < 16; i++) begin
      neg();
      chk("t1_v", 32'(m_valid), 32'd1);
      chk("t1_d", 32'(m_data), 32'(i));
      chk("t1_last", 32'(m_last), 32'(i == 15));
      pos();
    end
    neg();
    chk("t1_end_v", 32'(m_valid), 32'd0);
    chk("t1_words", 32'(words_sent), 32'd16);
    chk("t1_rdcnt", 32'(rd_cnt), 32'd16);
    pos();

    // back-pressure with ready pattern 1,0,0
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    base = acc_cnt;
    for (int k = 0; k < 100 && acc_cnt - base < 8; k++) begin
      m_ready = (k % 3 == 0);
      cyc();
    end
    chk("t2_count", 32'(acc_cnt - base), 32'd8);
    chk("t2_lastbyte", 32'(last_acc), 32'hA7);
    m_ready = 1'b1;
    neg(); chk("t2_words", 32'(words_sent), 32'd24); pos();

    // empty FIFO, then a single byte
    repeat (4) cyc();
    neg();
    chk("t3_rd", 32'(rd_en), 32'd0);
    chk("t3_v", 32'(m_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    pos();
    rdb = rd_cnt;
    push(8'h5A);
    got = 1'b0;
    for (int j = 0; j < 10 && !got; j++) begin
      neg();
      if (m_valid) begin
        got = 1'b1;
        chk("t3_data", 32'(m_data), 32'h5A);
        chk("t3_last", 32'(m_last), 32'd0);
      end
      pos();
    end
    chk("t3_seen", 32'(got), 32'd1);
    neg();
    chk("t3_busy2", 32'(busy), 32'd1);
    chk("t3_words", 32'(words_sent), 32'd25);
    chk("t3_rd1", 32'(rd_cnt - rdb), 32'd1);
    pos();

    // async reset with the skid buffer full
    m_ready = 1'b0;
    rdb = rd_cnt;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    repeat (6) cyc();
    neg();
    chk("t4_full_v", 32'(m_valid), 32'd1);
    chk("t4_rd2", 32'(rd_cnt - rdb), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_v", 32'(m_valid), 32'd0);
    chk("t4_rst_d", 32'(m_data), 32'd0);
    chk("t4_rst_rd", 32'(rd_en), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_words", 32'(words_sent), 32'd0);
    chk("t4_b1_busy", 32'(b1_busy), 32'd0);
    chk("t4_b1_rd", 32'(b1_rd_en), 32'd0);
    mod_clear();
    #1 rst = 1'b0;
    pos();
    m_ready = 1'b1;
    base = acc_cnt;
    got = 1'b0;
    for (int j = 0; j < 10 && !got; j++) begin
      neg();
      if (m_valid) begin
        got = 1'b1;
        chk("t4_first", 32'(m_data), 32'h12);
        chk("t4_w0", 32'(words_sent), 32'd0);
      end
      pos();
    end
    chk("t4_seen", 32'(got), 32'd1);
    for (int j = 0; j < 40 && acc_cnt - base < 6; j++) cyc();
    chk("t4_lastbyte", 32'(last_acc), 32'h17);
    neg(); chk("t4_words", 32'(words_sent), 32'd6); pos();

    // enable drop after 5 beats of a 16-beat burst
    rst_pulse();
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    base = acc_cnt;
    rdb = rd_cnt;
    for (int j = 0; j < 40 && acc_cnt - base < 5; j++) cyc();
    enable = 1'b0; m_ready = 1'b0;
    repeat (3) cyc();
    neg();
    chk("t5_rd_stop", 32'(rd_cnt - rdb), 32'd7);
    chk("t5_rd_low", 32'(rd_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_hold", 32'(m_data), 32'h35);
    pos();
    m_ready = 1'b1;
    got = 1'b0;
    for (int j = 0; j < 20 && !got; j++) begin
      neg();
      if (!busy) got = 1'b1;
      pos();
    end
    chk("t5_idle", 32'(got), 32'd1);
    chk("t5_drained", 32'(acc_cnt - base), 32'd7);
    chk("t5_drain_last", 32'(last_acc), 32'h36);
    chk("t5_rd_total", 32'(rd_cnt - rdb), 32'd7);
    enable = 1'b1;
    for (int j = 0; j < 60 && acc_cnt - base < 16; j++) cyc();
    chk("t5_final", 32'(last_acc), 32'h3F);
    chk("t5_mlast", 32'(last_last), 32'd1);
    neg(); chk("t5_words", 32'(words_sent), 32'd16); pos();

    // counter wrap on a continuous stream
    rst_pulse();
    inf_src = 1'b1;
    base = acc_cnt;
    for (int j = 0; j < 70000 && acc_cnt - base < 65537; j++) cyc();
    m_ready = 1'b0;
    neg();
    chk("t6_count", 32'(acc_cnt - base), 32'd65537);
    chk("t6_words", 32'(words_sent), 32'd1);
    chk("t6_b1_words", 32'(b1_words), 32'd1);
    pos();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
